bsr_chain: RTL and testbench

Parametrised boundary-scan register chain: input cells, output cells and output-enable control cells between TDI and TDO. Provides capture, shift and update stages and four pin/core modes: normal, EXTEST, INTEST and CLAMP. Sits between the TAP controller/instruction decoder and the chip I/O ring. Successor to the fixed 9-in/5-out BSR, adding control cells, safe values and INTEST/CLAMP behaviour.

---
 rtl/bsr_chain.sv | 90 +++++++++
 tb/tb_bsr_chain.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bsr_chain.sv
// Boundary-scan register chain: input, output and output-enable cells between TDI and TDO.
// Latency: capture/shift/update take one TCK edge; pin/core muxing is combinational.
// Backpressure: none; the TAP strobes are obeyed every cycle that bsr_select is high.
module bsr_chain #(
    parameter int                    NUM_IN   = 9,
    parameter int                    NUM_OUT  = 5,
    parameter int                    NUM_CTRL = 1,
    parameter logic [NUM_OUT-1:0]    SAFE_OUT = '0,
    parameter logic [NUM_CTRL-1:0]   SAFE_OE  = '0
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  TDI,
    output logic                  TDO,
    input  logic                  bsr_select,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    input  logic [1:0]            mode,
    input  logic [NUM_IN-1:0]     parallel_in,
    output logic [NUM_IN-1:0]     to_system_logic,
    input  logic [NUM_OUT-1:0]    parallel_system_logic_out,
    input  logic [NUM_CTRL-1:0]   sys_oe,
    output logic [NUM_OUT-1:0]    to_output_pin,
    output logic [NUM_CTRL-1:0]   pin_oe
);

    localparam int L = NUM_IN + NUM_OUT + NUM_CTRL;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_EXTEST = 2'b01,
        MODE_INTEST = 2'b10,
        MODE_CLAMP  = 2'b11
    } mode_e;

    generate
        if (NUM_OUT % NUM_CTRL != 0) begin : g_bad_ctrl_ratio
            $error("bsr_chain: NUM_OUT must be a multiple of NUM_CTRL");
        end
    endgenerate

    logic [L-1:0]        scan;
    logic [L-1:0]        upd;
    logic [NUM_IN-1:0]   upd_in;
    logic [NUM_OUT-1:0]  upd_out;
    logic [NUM_CTRL-1:0] upd_ctrl;

    // Cell order from TDI: input cells, then output cells, then control cells.
    always_ff @(posedge TCK) begin
        if (!TRST) begin
            scan <= '0;
            upd  <= {SAFE_OE, SAFE_OUT, {NUM_IN{1'b0}}};
        end else if (bsr_select) begin
            if (capture_dr) begin
                scan <= {sys_oe, parallel_system_logic_out, parallel_in};
            end else if (shift_dr) begin
                scan <= {scan[L-2:0], TDI};
            end
            if (update_dr) begin
                upd <= scan;
            end
        end
    end

    assign TDO      = scan[L-1];
    assign upd_in   = upd[NUM_IN-1:0];
    assign upd_out  = upd[NUM_IN +: NUM_OUT];
    assign upd_ctrl = upd[NUM_IN+NUM_OUT +: NUM_CTRL];

    always_comb begin
        to_system_logic = parallel_in;
        to_output_pin   = parallel_system_logic_out;
        pin_oe          = sys_oe;
        case (mode_e'(mode))
            MODE_NORMAL: ;
            MODE_EXTEST, MODE_CLAMP: begin
                to_output_pin = upd_out;
                pin_oe        = upd_ctrl;
            end
            MODE_INTEST: begin
                to_system_logic = upd_in;
                to_output_pin   = SAFE_OUT;
                pin_oe          = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bsr_chain.sv
// Directed bench for bsr_chain with default parameters (9 in, 5 out, 1 control cell).
module tb_bsr_chain;

    logic       TCK = 1'b0;
    logic       TRST;
    logic       TDI;
    logic       TDO;
    logic       bsr_select;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic [1:0] mode;
    logic [8:0] parallel_in;
    logic [8:0] to_system_logic;
    logic [4:0] parallel_system_logic_out;
    logic [0:0] sys_oe;
    logic [4:0] to_output_pin;
    logic [0:0] pin_oe;

    int total = 0;
    int bad   = 0;

    logic [14:0] vec_cap;
    logic [14:0] vec_ld;
    logic [14:0] vec_p;

    bsr_chain dut (
        .TCK                       (TCK),
        .TRST                      (TRST),
        .TDI                       (TDI),
        .TDO                       (TDO),
        .bsr_select                (bsr_select),
        .capture_dr                (capture_dr),
        .shift_dr                  (shift_dr),
        .update_dr                 (update_dr),
        .mode                      (mode),
        .parallel_in               (parallel_in),
        .to_system_logic           (to_system_logic),
        .parallel_system_logic_out (parallel_system_logic_out),
        .sys_oe                    (sys_oe),
        .to_output_pin             (to_output_pin),
        .pin_oe                    (pin_oe)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Inputs move 1 time unit after the rising edge; checks follow immediately.
    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    initial begin
        TRST = 1'b0; TDI = 1'b0; bsr_select = 1'b0;
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        mode = 2'b01;
        parallel_in = 9'h1A5; parallel_system_logic_out = 5'h13; sys_oe = 1'b1;
        vec_cap = {1'b1, 5'h13, 9'h1A5};
        vec_ld  = {1'b1, 5'h0A, 9'h0F0};
        vec_p   = {1'b1, 5'h16, 9'h12D};
        tick(); tick();
        TRST = 1'b1;
        #1;

        chk("rst_tdo", TDO, 0);
        chk("rst_ext_pin", to_output_pin, 5'h00);
        chk("rst_ext_oe", pin_oe, 0);
        chk("rst_ext_core", to_system_logic, 9'h1A5);
        mode = 2'b00; #1;
        chk("norm_pin", to_output_pin, 5'h13);
        chk("norm_oe", pin_oe, 1);
        chk("norm_core", to_system_logic, 9'h1A5);

        bsr_select = 1'b1; capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        chk("cap_tdo0", TDO, vec_cap[14]);
        shift_dr = 1'b1; TDI = 1'b0;
        for (int i = 1; i < 15; i++) begin
            tick();
            chk($sformatf("cap_tdo%0d", i), TDO, vec_cap[14-i]);
        end

        for (int i = 0; i < 15; i++) begin
            TDI = vec_ld[14-i];
            tick();
        end
        shift_dr = 1'b0;
        chk("ld_tdo", TDO, 1);
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        mode = 2'b01; #1;
        chk("ext_pin", to_output_pin, 5'h0A);
        chk("ext_oe", pin_oe, 1);
        chk("ext_core", to_system_logic, 9'h1A5);
        mode = 2'b10; #1;
        chk("int_core", to_system_logic, 9'h0F0);
        chk("int_pin", to_output_pin, 5'h00);
        chk("int_oe", pin_oe, 0);
        mode = 2'b11; #1;
        chk("clamp_pin", to_output_pin, 5'h0A);
        chk("clamp_oe", pin_oe, 1);
        mode = 2'b00; #1;
        chk("norm_pin2", to_output_pin, 5'h13);

        // All three strobes at once: capture wins on scan, upd takes the old scan.
        parallel_in = 9'h033; parallel_system_logic_out = 5'h05; sys_oe = 1'b0;
        capture_dr = 1'b1; shift_dr = 1'b1; update_dr = 1'b1;
        tick();
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        mode = 2'b01; #1;
        chk("all3_tdo", TDO, 0);
        chk("all3_pin", to_output_pin, 5'h0A);
        chk("all3_oe", pin_oe, 1);
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        chk("upd2_pin", to_output_pin, 5'h05);
        chk("upd2_oe", pin_oe, 0);
        mode = 2'b10; #1;
        chk("upd2_core", to_system_logic, 9'h033);

        bsr_select = 1'b0;
        parallel_in = 9'h1FF; parallel_system_logic_out = 5'h1F; sys_oe = 1'b1;
        capture_dr = 1'b1; shift_dr = 1'b1; update_dr = 1'b1;
        tick();
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        chk("desel_tdo", TDO, 0);
        chk("desel_core", to_system_logic, 9'h033);
        mode = 2'b01; #1;
        chk("desel_pin", to_output_pin, 5'h05);
        mode = 2'b00; #1;
        chk("desel_norm", to_output_pin, 5'h1F);

        bsr_select = 1'b1; shift_dr = 1'b1; TDI = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        TRST = 1'b0;
        tick();
        TRST = 1'b1; shift_dr = 1'b0;
        mode = 2'b01; #1;
        chk("mrst_tdo", TDO, 0);
        chk("mrst_pin", to_output_pin, 5'h00);
        chk("mrst_oe", pin_oe, 0);
        mode = 2'b10; #1;
        chk("mrst_core", to_system_logic, 9'h000);

        shift_dr = 1'b1;
        for (int i = 0; i < 15; i++) begin
            TDI = vec_p[14-i];
            tick();
            if (i < 14) chk($sformatf("post_tdo%0d", i), TDO, 0);
        end
        shift_dr = 1'b0;
        chk("post_tdo14", TDO, vec_p[14]);
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        chk("post_core", to_system_logic, 9'h12D);
        mode = 2'b01; #1;
        chk("post_pin", to_output_pin, 5'h16);
        chk("post_oe", pin_oe, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
